jno_flag_gen: RTL and testbench

Producer side of the JNO condition path. It keeps the registered overflow and carry flags, drives the 2-bit `check` vector to the branch checker, and resolves JNO requests. Resolution waits until all outstanding ALU operations have written their flags, then returns a taken/not-taken result over a valid/ack handshake. It sits between the ALU writeback and the PC-update logic.

---
 rtl/jno_flag_gen_pkg.sv | 19 +
 rtl/jno_flag_gen_pend_counter.sv | 41 ++++
 rtl/jno_flag_gen.sv | 113 +++++++++++
 tb/tb_jno_flag_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jno_flag_gen_pkg.sv
// Shared definitions for the JNO condition path: FSM encodings, check-vector
// bit positions and the resolve condition.
package jno_flag_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESOLVE = 2'd2
    } jno_state_e;

    localparam int CHK_OVF   = 1;
    localparam int CHK_CARRY = 0;

    // Flags are final only when nothing is outstanding and nothing writes this cycle.
    function automatic logic flags_settled(input logic zero, input logic alu_valid);
        return zero && !alu_valid;
    endfunction

endpackage

// File: rtl/jno_flag_gen_pend_counter.sv
// Saturating up/down counter of outstanding ALU ops with registered full flag.
module pend_counter #(
    parameter int PEND_W = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic zero_o
);

    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] count_q, count_d;
    logic              full_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            if (!full_q) count_d = count_q + PEND_W'(1);
        end else if (dec_i && !inc_i) begin
            // A completion with nothing outstanding is a protocol error; hold at 0.
            if (count_q != '0) count_d = count_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CNT_MAX);
        end
    end

    assign full_o = full_q;
    assign zero_o = (count_q == '0);

endmodule

// File: rtl/jno_flag_gen.sv
// JNO producer: registered overflow/carry flags, outstanding-op tracking and a
// request FSM returning taken/not-taken over a valid/ack handshake.
module jno_flag_gen
    import jno_flag_gen_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_issue,
    input  logic              alu_valid,
    input  logic              alu_ovf,
    input  logic              alu_carry,
    input  logic              flag_clr,
    output logic              alu_full,
    input  logic              jno_req,
    input  logic [ADDR_W-1:0] jno_target,
    output logic              jno_ready,
    output logic [1:0]        check,
    output logic              resolve_valid,
    output logic              resolve_taken,
    output logic [ADDR_W-1:0] resolve_target,
    input  logic              resolve_ack,
    output logic [1:0]        dbg_state
);

    // Handshakes: jno_req is accepted in a cycle where jno_req && jno_ready;
    // a result transfers in a cycle where resolve_valid && resolve_ack, and
    // resolve_* stay stable from rising valid until that transfer.

    logic              ovf_q, carry_q;
    logic              pend_zero, pend_full;
    logic              settled;
    jno_state_e        state_q;
    logic              rvalid_q, rtaken_q;
    logic [ADDR_W-1:0] rtarget_q;

    pend_counter #(.PEND_W(PEND_W)) u_pend (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (alu_issue),
        .dec_i   (alu_valid),
        .full_o  (pend_full),
        .zero_o  (pend_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (alu_valid) begin
            ovf_q   <= alu_ovf;
            carry_q <= alu_carry;
        end else if (flag_clr) begin
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
        end
    end

    assign settled = flags_settled(pend_zero, alu_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rvalid_q  <= 1'b0;
            rtaken_q  <= 1'b0;
            rtarget_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (jno_req) begin
                        rtarget_q <= jno_target;
                        if (settled) begin
                            rtaken_q <= ~ovf_q;
                            rvalid_q <= 1'b1;
                            state_q  <= ST_RESOLVE;
                        end else begin
                            state_q  <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (settled) begin
                        rtaken_q <= ~ovf_q;
                        rvalid_q <= 1'b1;
                        state_q  <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    if (resolve_ack) begin
                        rvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    rvalid_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign check[CHK_OVF]   = ovf_q;
    assign check[CHK_CARRY] = carry_q;
    assign alu_full         = pend_full;
    assign jno_ready        = (state_q == ST_IDLE) && !reset;
    assign resolve_valid    = rvalid_q;
    assign resolve_taken    = rtaken_q;
    assign resolve_target   = rtarget_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_jno_flag_gen.sv
// Bench for jno_flag_gen: directed scenarios then random traffic, all checked
// each cycle against a behavioural model and a queue of expected results.
module tb_jno_flag_gen;

    localparam int ADDR_W  = 8;
    localparam int PEND_W  = 2;
    localparam int PEND_MX = (1 << PEND_W) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              alu_issue = 0, alu_valid = 0, alu_ovf = 0, alu_carry = 0, flag_clr = 0;
    logic              jno_req = 0, resolve_ack = 0;
    logic [ADDR_W-1:0] jno_target = '0;
    logic              alu_full, jno_ready, resolve_valid, resolve_taken;
    logic [1:0]        check, dbg_state;
    logic [ADDR_W-1:0] resolve_target;

    always #5 clk = ~clk;

    jno_flag_gen #(.ADDR_W(ADDR_W), .PEND_W(PEND_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_issue      (alu_issue),
        .alu_valid      (alu_valid),
        .alu_ovf        (alu_ovf),
        .alu_carry      (alu_carry),
        .flag_clr       (flag_clr),
        .alu_full       (alu_full),
        .jno_req        (jno_req),
        .jno_target     (jno_target),
        .jno_ready      (jno_ready),
        .check          (check),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .resolve_ack    (resolve_ack),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [ADDR_W:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A request is either waiting for flags (m_wait) or presenting a result (m_res).
    int              m_pend;
    bit              m_ovf, m_carry, m_wait, m_res, m_taken;
    logic [ADDR_W-1:0] m_target;

    task automatic model_reset();
        m_pend = 0; m_ovf = 0; m_carry = 0;
        m_wait = 0; m_res = 0; m_taken = 0; m_target = '0;
        exp_q.delete();
    endtask

    task automatic model_clock();
        bit settled;
        if (reset) begin
            model_reset();
            return;
        end
        settled = (m_pend == 0) && !alu_valid;
        if (m_res) begin
            if (resolve_ack) m_res = 0;
        end else if (m_wait) begin
            if (settled) begin
                m_wait = 0; m_res = 1; m_taken = !m_ovf;
                exp_q.push_back({m_taken, m_target});
            end
        end else if (jno_req) begin
            m_target = jno_target;
            if (settled) begin
                m_res = 1; m_taken = !m_ovf;
                exp_q.push_back({m_taken, m_target});
            end else begin
                m_wait = 1;
            end
        end
        if (alu_valid) begin
            m_ovf = alu_ovf; m_carry = alu_carry;
        end else if (flag_clr) begin
            m_ovf = 0; m_carry = 0;
        end
        if (alu_issue && !alu_valid && m_pend < PEND_MX) m_pend++;
        else if (alu_valid && !alu_issue && m_pend > 0) m_pend--;
    endtask

    task automatic compare_outputs();
        check_eq("check", check, {m_ovf, m_carry});
        check_eq("alu_full", alu_full, m_pend == PEND_MX);
        check_eq("jno_ready", jno_ready, !m_wait && !m_res && !reset);
        check_eq("resolve_valid", resolve_valid, m_res);
        check_eq("state", dbg_state, m_res ? 2'd2 : (m_wait ? 2'd1 : 2'd0));
        if (m_res) begin
            check_eq("resolve_taken", resolve_taken, m_taken);
            check_eq("resolve_target", resolve_target, m_target);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs at the falling edge, clock the model at the
    // rising edge, then compare at the next falling edge.
    task automatic step(input bit rst, input bit iss, input bit vld, input bit ov, input bit cy,
                        input bit clr, input bit req, input logic [ADDR_W-1:0] tgt, input bit ack);
        logic [ADDR_W:0] exp;
        reset = rst; alu_issue = iss; alu_valid = vld; alu_ovf = ov; alu_carry = cy;
        flag_clr = clr; jno_req = req; jno_target = tgt; resolve_ack = ack;
        if (!rst && ack && m_res) begin
            if (exp_q.size() == 0) begin
                check_eq("handshake_queue_empty", 1, 0);
            end else begin
                exp = exp_q.pop_front();
                check_eq("handshake", {resolve_taken, resolve_target}, exp);
            end
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0, 0, '0, 0);
        step(1, 0, 0, 0, 0, 0, 0, '0, 0);
        check_eq("rst_check", check, 2'b00);
        check_eq("rst_taken", resolve_taken, 1'b0);
        check_eq("rst_target", resolve_target, 8'h00);
        check_eq("rst_ready_low", jno_ready, 1'b0);

        // Flag write then clear.
        step(0, 0, 1, 1, 0, 0, 0, '0, 0);
        check_eq("flag_10", check, 2'b10);
        step(0, 0, 0, 0, 0, 1, 0, '0, 0);
        check_eq("flag_clr", check, 2'b00);

        // Immediate resolve, held until ack.
        step(0, 0, 0, 0, 0, 0, 1, 8'h3C, 0);
        check_eq("imm_valid", resolve_valid, 1'b1);
        check_eq("imm_taken", resolve_taken, 1'b1);
        check_eq("imm_target", resolve_target, 8'h3C);
        idle_step();
        idle_step();
        check_eq("imm_hold", {resolve_valid, resolve_taken, resolve_target}, {2'b11, 8'h3C});
        step(0, 0, 0, 0, 0, 0, 0, '0, 1);
        check_eq("imm_ack", resolve_valid, 1'b0);

        // Wait for an outstanding op that sets overflow.
        step(0, 1, 0, 0, 0, 0, 0, '0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'h55, 0);
        check_eq("wait_state", dbg_state, 2'd1);
        idle_step();
        step(0, 0, 1, 1, 1, 0, 0, '0, 0);
        check_eq("wait_still", resolve_valid, 1'b0);
        idle_step();
        check_eq("wait_valid", resolve_valid, 1'b1);
        check_eq("wait_taken", resolve_taken, 1'b0);
        step(0, 0, 0, 0, 0, 1, 0, '0, 1);

        // Saturation: three issues fill, fourth dropped, three completions drain.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, '0, 0);
        check_eq("full", alu_full, 1'b1);
        step(0, 0, 0, 0, 0, 0, 1, 8'hA7, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 0, 0, '0, 0);
        check_eq("drain_not_full", alu_full, 1'b0);
        idle_step();
        check_eq("drain_valid", resolve_valid, 1'b1);
        check_eq("drain_taken", resolve_taken, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, '0, 1);

        // Issue and completion together at count 1 keep the request waiting.
        step(0, 1, 0, 0, 0, 0, 0, '0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'h12, 0);
        step(0, 1, 1, 0, 0, 0, 0, '0, 0);
        idle_step();
        check_eq("same_cycle_wait", dbg_state, 2'd1);
        step(0, 0, 1, 0, 0, 0, 0, '0, 0);
        idle_step();
        check_eq("same_cycle_done", resolve_valid, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, '0, 1);

        // Reset while presenting a result.
        step(0, 0, 1, 1, 1, 0, 0, '0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'hEE, 0);
        check_eq("pre_rst_valid", resolve_valid, 1'b1);
        step(1, 0, 0, 0, 0, 0, 0, '0, 0);
        check_eq("mid_rst_valid", resolve_valid, 1'b0);
        check_eq("mid_rst_check", check, 2'b00);
        idle_step();
        check_eq("post_rst_ready", jno_ready, 1'b1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bit vld;
            vld = (m_pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            step($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, vld,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                 1'($urandom_range(0, 1)), ADDR_W'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
